// File: rtl/wait_state_memory.sv
// Bus responder backed by a word-organised RAM: programmable wait states per transfer type,
// abort on out-of-range or user-mode writes into the protected low region.
module wait_state_memory #(
    parameter int DEPTH      = 1024,
    parameter int NSEQ_WAIT  = 2,
    parameter int SEQ_WAIT   = 0,
    parameter int PROT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        data_valid,
    output logic        abort,
    input  logic        write,
    input  logic        size,
    input  logic [1:0]  prot,
    input  logic [1:0]  trans
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, wdata_q;
    logic           write_q, size_q, priv_q;
    logic           accept, enter_resp;

    logic           dv_q, ab_q, zero_q, bsel_q;
    logic [1:0]     blane_q;

    // With zero wait states the response edge is the accept edge, so the live
    // inputs stand in for the latched request while still in IDLE.
    logic           use_live;
    logic [31:0]    cur_addr, cur_wdata;
    logic           cur_write, cur_size, cur_priv, cur_abort;
    logic [29:0]    cur_idx;
    logic [AW-1:0]  ram_idx;
    logic [1:0]     cur_lane;
    logic [3:0]     lane_en;
    logic           we, re;
    logic [7:0]     rd_bytes [4];

    assign use_live  = (state_q == IDLE);
    assign cur_addr  = use_live ? addr  : addr_q;
    assign cur_wdata = use_live ? wdata : wdata_q;
    assign cur_write = use_live ? write : write_q;
    assign cur_size  = use_live ? size  : size_q;
    assign cur_priv  = use_live ? prot[1] : priv_q;
    assign cur_idx   = cur_addr[31:2];
    assign cur_lane  = cur_addr[1:0];
    assign ram_idx   = cur_idx[AW-1:0];
    assign cur_abort = (cur_idx >= 30'(DEPTH)) ||
                       (cur_write && !cur_priv && (cur_idx < 30'(PROT_LIMIT)));
    assign lane_en   = cur_size ? 4'hF : (4'b0001 << cur_lane);
    assign we        = enter_resp && !rst && !cur_abort && cur_write;
    assign re        = enter_resp && !rst && !cur_abort && !cur_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (trans[1]) begin
                    accept = 1'b1;
                    cnt_d  = (trans == 2'b11) ? CW'(SEQ_WAIT) : CW'(NSEQ_WAIT);
                    if (cnt_d != '0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d    = RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One RAM per byte lane keeps byte writes a plain per-lane write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_q;
            logic [7:0] wbyte;

            assign wbyte        = cur_size ? cur_wdata[gi*8 +: 8] : cur_wdata[7:0];
            assign rd_bytes[gi] = rd_q;

            always_ff @(posedge clk) begin
                if (we && lane_en[gi]) begin
                    lane_mem[ram_idx] <= wbyte;
                end
                if (re) begin
                    rd_q <= lane_mem[ram_idx];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= 1'b0;
            priv_q  <= 1'b0;
            dv_q    <= 1'b0;
            ab_q    <= 1'b0;
            zero_q  <= 1'b1;
            bsel_q  <= 1'b0;
            blane_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                write_q <= write;
                size_q  <= size;
                priv_q  <= prot[1];
            end
            dv_q <= enter_resp && !cur_abort;
            ab_q <= enter_resp && cur_abort;
            // Write responses leave the previous read data on rdata.
            if (enter_resp) begin
                if (cur_abort) begin
                    zero_q <= 1'b1;
                end else if (!cur_write) begin
                    zero_q  <= 1'b0;
                    bsel_q  <= !cur_size;
                    blane_q <= cur_lane;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!zero_q) begin
            if (bsel_q) begin
                rdata = {4{rd_bytes[blane_q]}};
            end else begin
                rdata = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
            end
        end
    end

    assign data_valid = dv_q;
    assign abort      = ab_q;

endmodule
